// File: rtl/vc_demux_pkg.sv
// Shared constants and default-width entry type for the val/rdy demux.
package vc_demux_pkg;

  localparam int VC_DEMUX_DEPTH      = 2;
  localparam int VC_DEMUX_CNT_NBITS  = 2;
  localparam int VC_DEMUX_MSG_NBITS  = 32;
  localparam int VC_DEMUX_SEL_NBITS  = 3;

  typedef struct packed {
    logic [VC_DEMUX_MSG_NBITS-1:0] msg;
    logic [VC_DEMUX_SEL_NBITS-1:0] sel;
  } vc_demux_entry_t;

endpackage

// File: rtl/vc_demux_buf.sv
// Two-entry FIFO for the demux; in_rdy-side ready is a register so no
// combinational path exists from the dequeue side to the enqueue side.
module vc_demux_buf
  import vc_demux_pkg::*;
#(
  parameter int p_width = $bits(vc_demux_entry_t)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq,
  input  logic [p_width-1:0] enq_data,
  input  logic               deq,
  output logic [p_width-1:0] head_data,
  output logic               full,
  output logic               empty,
  output logic               enq_rdy
);

  logic [p_width-1:0]            mem [VC_DEMUX_DEPTH];
  logic                          head, tail;
  logic [VC_DEMUX_CNT_NBITS-1:0] count, count_next;
  logic                          do_enq, do_deq;

  assign full      = (count == VC_DEMUX_CNT_NBITS'(VC_DEMUX_DEPTH));
  assign empty     = (count == '0);
  assign do_enq    = enq & ~full;
  assign do_deq    = deq & ~empty;
  assign head_data = mem[head];

  always_comb begin
    count_next = count;
    case ({do_enq, do_deq})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= '0;
      enq_rdy <= 1'b0;
      for (int i = 0; i < VC_DEMUX_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_enq) begin
        mem[tail] <= enq_data;
        tail      <= ~tail;
      end
      if (do_deq) head <= ~head;
      count   <= count_next;
      // Ready for the next cycle is decided from the post-update occupancy.
      enq_rdy <= (count_next != VC_DEMUX_CNT_NBITS'(VC_DEMUX_DEPTH));
    end
  end

endmodule

// File: rtl/vc_val_rdy_demux.sv
// 1-to-N val/rdy demux with a 2-entry decoupling buffer.
// Define VC_VAL_RDY_DEMUX_ERR_EN to drop out-of-range selects and pulse err.
module vc_val_rdy_demux
  import vc_demux_pkg::*;
#(
  parameter int p_nbits     = 32,
  parameter int p_nouts     = 4,
  parameter int p_sel_nbits = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_nbits-1:0]     in_msg,
  input  logic [p_sel_nbits-1:0] in_sel,
  output logic [p_nouts-1:0]     out_val,
  input  logic [p_nouts-1:0]     out_rdy,
  output logic [p_nbits-1:0]     out_msg,
  output logic                   err
);

  typedef struct packed {
    logic [p_nbits-1:0]     msg;
    logic [p_sel_nbits-1:0] sel;
  } entry_t;

  localparam logic [p_sel_nbits-1:0] LAST = p_sel_nbits'(p_nouts - 1);

  entry_t enq_ent, head;
  logic   oob, fire, enq, deq, full, empty;

  assign oob  = (in_sel > LAST);
  assign fire = in_val & in_rdy;

`ifdef VC_VAL_RDY_DEMUX_ERR_EN
  assign enq         = fire & ~oob;
  assign enq_ent.sel = in_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= fire & oob;
  end
`else
  assign enq         = fire;
  assign enq_ent.sel = oob ? LAST : in_sel;
  assign err         = 1'b0;
`endif

  assign enq_ent.msg = in_msg;

  vc_demux_buf #(.p_width($bits(entry_t))) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq       (enq),
    .enq_data  (enq_ent),
    .deq       (deq),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .enq_rdy   (in_rdy)
  );

  genvar i;
  generate
    for (i = 0; i < p_nouts; i++) begin : g_val
      assign out_val[i] = ~empty & (head.sel == p_sel_nbits'(i));
    end
  endgenerate

  // Only the selected output's ready matters; out_val is one-hot or zero.
  assign deq     = |(out_val & out_rdy);
  assign out_msg = empty ? '0 : head.msg;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_vc_val_rdy_demux.sv
// Randomized and directed bench for vc_val_rdy_demux against a queue model.
module tb_vc_val_rdy_demux;

  logic        clk, reset_n;
  logic        in_val, in_rdy, err;
  logic [31:0] in_msg, out_msg;
  logic [2:0]  in_sel;
  logic [3:0]  out_val, out_rdy;

  vc_val_rdy_demux #(.p_nbits(32), .p_nouts(4), .p_sel_nbits(3)) dut (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .in_sel(in_sel), .out_val(out_val), .out_rdy(out_rdy),
    .out_msg(out_msg), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] msg; int sel; } ent_t;
  ent_t mq[$];
  logic rdy_m, err_m;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs, advance the model at posedge.
  task automatic cyc(input logic v, input logic [31:0] m, input logic [2:0] s,
                     input logic [3:0] r);
    logic [3:0]  ev;
    logic [31:0] em;
    logic        fire, dq;
    in_val = v; in_msg = m; in_sel = s; out_rdy = r;
    #1;
    ev = '0; em = '0;
    if (mq.size() > 0) begin ev[mq[0].sel] = 1'b1; em = mq[0].msg; end
    chk("in_rdy", 64'(in_rdy), 64'(rdy_m));
    chk("out_val", 64'(out_val), 64'(ev));
    chk("out_msg", 64'(out_msg), 64'(em));
    chk("err", 64'(err), 64'(err_m));
    fire = v && rdy_m;
    dq   = (mq.size() > 0) && r[mq[0].sel];
    @(posedge clk);
    if (dq) mq.delete(0);
    err_m = 1'b0;
    if (fire) begin
      if (int'(s) >= 4) begin
`ifdef VC_VAL_RDY_DEMUX_ERR_EN
        err_m = 1'b1;
`else
        mq.push_back('{msg: m, sel: 3});
`endif
      end else begin
        mq.push_back('{msg: m, sel: int'(s)});
      end
    end
    rdy_m = (mq.size() < 2);
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    rdy_m = 1'b0;
    err_m = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; in_val = 0; in_msg = 0; in_sel = 0; out_rdy = 0;
    model_reset();
    #3;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_msg", 64'(out_msg), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Single message
    cyc(1'b0, 32'h0, 3'd0, 4'hf);
    cyc(1'b1, 32'hDEADBEEF, 3'd2, 4'hf);
    #1;
    chk("single_val", 64'(out_val), 64'h4);
    chk("single_msg", 64'(out_msg), 64'hDEADBEEF);
    cyc(1'b0, 32'h0, 3'd0, 4'hf);
    #1;
    chk("single_gone", 64'(out_val), 64'h0);

    // Streaming
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h1000 + i, 3'(i % 4), 4'hf);
    cyc(1'b0, 32'h0, 3'd0, 4'hf);

    // Backpressure and head-of-line blocking
    cyc(1'b1, 32'hAAAA0001, 3'd1, 4'b1101);
    cyc(1'b1, 32'hBBBB0003, 3'd3, 4'b1101);
    cyc(1'b1, 32'hCCCC0000, 3'd0, 4'b1101);
    #1;
    chk("hol_rdy", 64'(in_rdy), 64'd0);
    chk("hol_val", 64'(out_val), 64'h2);
    cyc(1'b0, 32'h0, 3'd0, 4'hf);
    #1;
    chk("hol_b_next", 64'(out_val), 64'h8);
    chk("hol_b_msg", 64'(out_msg), 64'hBBBB0003);
    cyc(1'b0, 32'h0, 3'd0, 4'hf);

    // Full buffer with simultaneous dequeue: no enqueue, ready next cycle
    cyc(1'b1, 32'h11, 3'd0, 4'h0);
    cyc(1'b1, 32'h22, 3'd1, 4'h0);
    cyc(1'b1, 32'h33, 3'd2, 4'hf);
    #1;
    chk("full_deq_rdy", 64'(in_rdy), 64'd1);
    cyc(1'b0, 32'h0, 3'd0, 4'hf);
    cyc(1'b0, 32'h0, 3'd0, 4'hf);

    // Out-of-range select
    cyc(1'b1, 32'h55AA55AA, 3'd5, 4'hf);
    #1;
`ifdef VC_VAL_RDY_DEMUX_ERR_EN
    chk("oob_err", 64'(err), 64'd1);
    chk("oob_noval", 64'(out_val), 64'h0);
`else
    chk("oob_err", 64'(err), 64'd0);
    chk("oob_clamp", 64'(out_val), 64'h8);
`endif
    cyc(1'b0, 32'h0, 3'd0, 4'hf);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
          4'($urandom));
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 3'd0, 4'hf);

    // Reset mid-operation with two messages buffered
    cyc(1'b1, 32'h77770000, 3'd1, 4'h0);
    cyc(1'b1, 32'h88880000, 3'd2, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_val", 64'(out_val), 64'h0);
    chk("mid_rst_rdy", 64'(in_rdy), 64'd0);
    chk("mid_rst_msg", 64'(out_msg), 64'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 3'd0, 4'hf);
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 3)), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
